alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 20-bit combinational ALU. WIDTH is configurable, and the block adds status flags and an iterative multiply.
- Accepts one operation per transaction over a valid/ready input, executes it, and holds a registered result plus flags until the consumer takes it.
- Sits between the datapath register file and writeback. Backpressure comes from the writeback stage.

Parameters:
- WIDTH, 20, operand/result width in bits; minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B; unsigned shift amount for shifts.
- opCode  input  3  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- EqualFlag  output  1  in1 == in2, captured at accept.
- ZeroFlag  output  1  result == 0.
- CarryFlag  output  1  ADD: carry out; SUB: borrow (in1 < in2 unsigned); otherwise 0.
- OverflowFlag  output  1  ADD/SUB: signed two's-complement overflow; MUL: upper WIDTH bits of full product nonzero; otherwise 0.

Behaviour:
- Opcodes:
  - 000 ADD; 001 SUB (in1-in2); 010 AND; 011 OR; 100 XOR.
  - 101 SHL: in1<<in2, logical.
  - 110 SHR: in1>>in2, logical.
  - 111 MUL: low WIDTH bits of unsigned in1*in2.
- Shifts: in2 >= WIDTH gives result 0.
- All arithmetic is modulo 2^WIDTH.
- States: IDLE, MUL, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept occurs when in_valid && in_ready:
  - in1, in2 and opCode are captured.
  - EqualFlag is computed from the captured operands.
- Non-MUL ops:
  - IDLE->DONE on accept.
  - result and flags are valid on the next cycle; latency 1.
- MUL (shift-add, one multiplier bit per cycle):
  - IDLE->MUL on accept; the bit counter clears.
  - After WIDTH iterations, MUL->DONE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - A full 2*WIDTH product is accumulated internally for OverflowFlag.
- DONE:
  - result and all flags are held stable while out_ready=0.
  - On out_valid && out_ready, DONE->IDLE; in_ready is 1 on the next cycle.
  - No same-cycle turnaround: sustained throughput is one non-MUL op per 2 cycles.
- in_valid is ignored while in_ready=0. Inputs may change freely after accept.
- Reset, at any time including mid-MUL or in DONE:
  - state returns to IDLE and the iteration is abandoned.
  - result, all flags and out_valid are 0; in_ready is 1 on the cycle after reset deasserts.
- ZeroFlag is derived from the final registered result.

Decomposition:
- Shared include header alu_defs.vh holds:
  - opcode localparams OP_ADD..OP_MUL;
  - state encodings S_IDLE, S_MUL, S_DONE.
- One sub-module, alu_mul_iter, is natural:
  - parametrised WIDTH;
  - start / done / product[2*WIDTH-1:0];
  - synchronous active-high reset.
  - alu_seq owns the handshake FSM and the single-cycle ops.

Test Plan:
- ADD: in1=0x000FF, in2=0x00055 -> 1 cycle after accept:
  - result=0x00154;
  - Zero=0, Carry=0, Overflow=0, Equal=0.
- SUB, borrow case: in1=0x00055, in2=0x000FF -> result=0xFFF56, Carry=1, Overflow=0.
- SUB, equal operands: in1=in2=0x000FF -> result=0, Zero=1, Equal=1.
- ADD overflow: in1=0x7FFFF, in2=0x00001 -> result=0x80000, Overflow=1, Carry=0.
- MUL: in1=0x000FF, in2=0x00055:
  - out_valid rises exactly 21 cycles after accept;
  - result=0x054AB, Overflow=0.
- MUL overflow: in1=0x80000, in2=0x00002 -> result=0, Zero=1, Overflow=1.
- SHL: in1=0x000FF, in2=20 -> result=0, Zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands during that window:
  - result and flags stay stable;
  - in_ready stays 0 and the new operands are not accepted;
  - out_ready=1 gives in_ready=1 on the next cycle.
- Reset mid-MUL: assert reset 8 cycles after accepting a MUL:
  - next cycle out_valid=0, result=0, in_ready=1;
  - a following ADD 0x000FF+0x00055 returns 0x00154.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode and state encodings for alu_seq
package alu_seq_pkg;

  // Operation select encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Handshake FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
  parameter int WIDTH = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      // Last iteration: the accumulator holds the full product on the next cycle
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with status flags and iterative multiply
import alu_seq_pkg::*;

module alu_seq #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       opCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             EqualFlag,
  output logic             ZeroFlag,
  output logic             CarryFlag,
  output logic             OverflowFlag
);

  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               equal_q;
  logic               zero_q;
  logic               carry_q;
  logic               ovf_q;

  logic [WIDTH-1:0]   result_d;
  logic               carry_d;
  logic               ovf_d;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign accept    = (state_q == S_IDLE) && in_valid;
  assign mul_start = accept && (opCode == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (in1),
    .b       (in2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle operations and their carry/overflow, evaluated on the live inputs at accept
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    add_w    = {1'b0, in1} + {1'b0, in2};
    sub_w    = {1'b0, in1} - {1'b0, in2};
    case (opCode)
      OP_ADD: begin
        result_d = add_w[WIDTH-1:0];
        carry_d  = add_w[WIDTH];
        ovf_d    = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_w[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = sub_w[WIDTH-1:0];
        carry_d  = sub_w[WIDTH];
        ovf_d    = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_w[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: result_d = in1 & in2;
      OP_OR:  result_d = in1 | in2;
      OP_XOR: result_d = in1 ^ in2;
      OP_SHL: result_d = (in2 >= WIDTH'(WIDTH)) ? '0 : (in1 << in2);
      OP_SHR: result_d = (in2 >= WIDTH'(WIDTH)) ? '0 : (in1 >> in2);
      default: result_d = '0;
    endcase
  end

  // Handshake FSM with registered result and flags held until the consumer takes them
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      equal_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            equal_q <= (in1 == in2);
            if (opCode == OP_MUL) begin
              state_q <= S_MUL;
            end else begin
              result_q <= result_d;
              zero_q   <= (result_d == '0);
              carry_q  <= carry_d;
              ovf_q    <= ovf_d;
              state_q  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            result_q <= mul_product[WIDTH-1:0];
            zero_q   <= (mul_product[WIDTH-1:0] == '0);
            carry_q  <= 1'b0;
            ovf_q    <= |mul_product[2*WIDTH-1:WIDTH];
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign EqualFlag    = equal_q;
  assign ZeroFlag     = zero_q;
  assign CarryFlag    = carry_q;
  assign OverflowFlag = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in1;
  logic [19:0] in2;
  logic [2:0]  opCode;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] result;
  logic        EqualFlag;
  logic        ZeroFlag;
  logic        CarryFlag;
  logic        OverflowFlag;

  int n_checks;
  int n_fail;

  alu_seq #(.WIDTH(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in1          (in1),
    .in2          (in2),
    .opCode       (opCode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .EqualFlag    (EqualFlag),
    .ZeroFlag     (ZeroFlag),
    .CarryFlag    (CarryFlag),
    .OverflowFlag (OverflowFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, then count cycles after the accept edge until out_valid (-1 on timeout)
  task automatic issue(input logic [19:0] a, input logic [19:0] b, input logic [2:0] op,
                       output int lat);
    @(negedge clk);
    in1 = a; in2 = b; opCode = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = 20'($urandom);
    in2 = 20'($urandom);
    opCode = 3'($urandom);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 20'h0}) begin
      n_fail++;
      $display("FAIL reset_state got valid=%b ready=%b result=%h exp valid=0 ready=1 result=00000",
               out_valid, in_ready, result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got ZCOE=%b exp 0000",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    issue(20'h000FF, 20'h00055, 3'b000, lat);
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL add_latency got %0d exp 0", lat);
    end
    n_checks++;
    if (result !== 20'h00154) begin
      n_fail++;
      $display("FAIL add_result got %h exp 00154", result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_flags got ZCOE=%b exp 0000",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    release_out();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_sub_borrow();
    int lat;
    issue(20'h00055, 20'h000FF, 3'b001, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'hFFF56) begin
      n_fail++;
      $display("FAIL sub_borrow_result got lat=%0d result=%h exp lat=0 result=fff56", lat, result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b0100) begin
      n_fail++;
      $display("FAIL sub_borrow_flags got ZCOE=%b exp 0100",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    release_out();
  endtask

  task automatic test_sub_equal();
    int lat;
    issue(20'h000FF, 20'h000FF, 3'b001, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h00000) begin
      n_fail++;
      $display("FAIL sub_equal_result got lat=%0d result=%h exp lat=0 result=00000", lat, result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b1001) begin
      n_fail++;
      $display("FAIL sub_equal_flags got ZCOE=%b exp 1001",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    release_out();
  endtask

  task automatic test_add_overflow();
    int lat;
    issue(20'h7FFFF, 20'h00001, 3'b000, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h80000) begin
      n_fail++;
      $display("FAIL add_ovf_result got lat=%0d result=%h exp lat=0 result=80000", lat, result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b0010) begin
      n_fail++;
      $display("FAIL add_ovf_flags got ZCOE=%b exp 0010",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    release_out();
  endtask

  task automatic test_mul();
    int lat;
    issue(20'h000FF, 20'h00055, 3'b111, lat);
    n_checks++;
    if (lat !== 21) begin
      n_fail++;
      $display("FAIL mul_latency got %0d exp 21", lat);
    end
    n_checks++;
    if (result !== 20'h054AB) begin
      n_fail++;
      $display("FAIL mul_result got %h exp 054ab", result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mul_flags got ZCOE=%b exp 0000",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    release_out();
  endtask

  task automatic test_mul_overflow();
    int lat;
    issue(20'h80000, 20'h00002, 3'b111, lat);
    n_checks++;
    if (lat !== 21 || result !== 20'h00000) begin
      n_fail++;
      $display("FAIL mul_ovf_result got lat=%0d result=%h exp lat=21 result=00000", lat, result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mul_ovf_flags got ZCOE=%b exp 1010",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    release_out();
  endtask

  task automatic test_shifts();
    int lat;
    issue(20'h000FF, 20'd20, 3'b101, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h00000 || ZeroFlag !== 1'b1) begin
      n_fail++;
      $display("FAIL shl_limit got lat=%0d result=%h zero=%b exp lat=0 result=00000 zero=1",
               lat, result, ZeroFlag);
    end
    release_out();
    issue(20'h000FF, 20'd4, 3'b101, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h00FF0 || ZeroFlag !== 1'b0) begin
      n_fail++;
      $display("FAIL shl_4 got lat=%0d result=%h zero=%b exp lat=0 result=00ff0 zero=0",
               lat, result, ZeroFlag);
    end
    release_out();
    issue(20'h80000, 20'd19, 3'b110, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h00001) begin
      n_fail++;
      $display("FAIL shr_19 got lat=%0d result=%h exp lat=0 result=00001", lat, result);
    end
    release_out();
    issue(20'hF0F0F, 20'h0FF00, 3'b100, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'hFF00F) begin
      n_fail++;
      $display("FAIL xor got lat=%0d result=%h exp lat=0 result=ff00f", lat, result);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(20'h12345, 20'h00001, 3'b000, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h12346) begin
      n_fail++;
      $display("FAIL bp_first got lat=%0d result=%h exp lat=0 result=12346", lat, result);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      in1 = 20'h00001;
      in2 = 20'h00001;
      opCode = 3'b010;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result, ZeroFlag, CarryFlag, OverflowFlag, EqualFlag}
          !== {1'b1, 1'b0, 20'h12346, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b result=%h ZCOE=%b exp valid=1 ready=0 result=12346 ZCOE=0000",
                 c, out_valid, in_ready, result,
                 {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
      end
    end
    in_valid = 1'b0;
    release_out();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_no_accept got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    @(negedge clk);
    in1 = 20'h000FF; in2 = 20'h00055; opCode = 3'b111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 20'h0}) begin
      n_fail++;
      $display("FAIL mid_mul_reset got valid=%b ready=%b result=%h exp valid=0 ready=1 result=00000",
               out_valid, in_ready, result);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag, OverflowFlag, EqualFlag} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_mul_reset_flags got ZCOE=%b exp 0000",
               {ZeroFlag, CarryFlag, OverflowFlag, EqualFlag});
    end
    @(negedge clk);
    reset = 1'b0;
    issue(20'h000FF, 20'h00055, 3'b000, lat);
    n_checks++;
    if (lat !== 0 || result !== 20'h00154) begin
      n_fail++;
      $display("FAIL post_reset_add got lat=%0d result=%h exp lat=0 result=00154", lat, result);
    end
    release_out();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    opCode    = '0;
    test_reset();
    test_add();
    test_sub_borrow();
    test_sub_equal();
    test_add_overflow();
    test_mul();
    test_mul_overflow();
    test_shifts();
    test_backpressure();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
